// File: rtl/depth_feed_sequencer_if.sv
// Snapshot, live and parser-feed level streams for the depth feed sequencer.
// slave is the sequencer side (consumes snap/live, drives out); master is the source/sink side.
interface depth_feed_sequencer_if;
  logic        snap_valid;
  logic        snap_ready;
  logic        snap_last;
  logic [63:0] snap_update_id;
  logic [63:0] snap_ts_ns;
  logic [7:0]  snap_side;
  logic [31:0] snap_price_f32;
  logic [31:0] snap_qty_f32;

  logic        live_valid;
  logic        live_ready;
  logic [63:0] live_ts_ns;
  logic [63:0] live_update_id;
  logic [7:0]  live_side;
  logic [31:0] live_price_f32;
  logic [31:0] live_qty_f32;

  logic        out_valid;
  logic [63:0] out_ts_ns;
  logic [63:0] out_update_id;
  logic [7:0]  out_side;
  logic [31:0] out_price_f32;
  logic [31:0] out_qty_f32;
  logic        out_is_snap;

  modport slave (
    input  snap_valid, snap_last, snap_update_id, snap_ts_ns, snap_side, snap_price_f32, snap_qty_f32,
    output snap_ready,
    input  live_valid, live_ts_ns, live_update_id, live_side, live_price_f32, live_qty_f32,
    output live_ready,
    output out_valid, out_ts_ns, out_update_id, out_side, out_price_f32, out_qty_f32, out_is_snap
  );

  modport master (
    output snap_valid, snap_last, snap_update_id, snap_ts_ns, snap_side, snap_price_f32, snap_qty_f32,
    input  snap_ready,
    output live_valid, live_ts_ns, live_update_id, live_side, live_price_f32, live_qty_f32,
    input  live_ready,
    input  out_valid, out_ts_ns, out_update_id, out_side, out_price_f32, out_qty_f32, out_is_snap
  );
endinterface

// File: rtl/depth_feed_sequencer.sv
// Book sync sequencer: replays REST snapshot levels, then live diffs in update_id order, resyncing on gaps.
// Latency 1 accept->out_valid; no parser backpressure, readies decoded from state and forced low by abort.
module depth_feed_sequencer #(
  parameter logic [63:0] MAX_GAP = 64'd1000,
  parameter int          CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  depth_feed_sequencer_if.slave feed,
  output logic [1:0]           state_o,
  output logic                 resync_req,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     gap_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SNAP   = 2'd1,
    ST_LIVE   = 2'd2,
    ST_RESYNC = 2'd3
  } state_t;

  typedef struct packed {
    logic [63:0] ts_ns;
    logic [63:0] update_id;
    logic [7:0]  side;
    logic [31:0] price_f32;
    logic [31:0] qty_f32;
    logic        is_snap;
  } beat_t;

  state_t           state_q, state_d;
  beat_t            beat_q, beat_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      snap_id_q, last_id_q;
  logic [CNT_W-1:0] drop_cnt_q, gap_cnt_q;

  logic        snap_rdy, live_rdy;
  logic        snap_fire, live_fire;
  logic [63:0] live_id, id_delta;
  logic        is_stale, is_regress, is_gap;
  logic        live_fwd, live_bad;

  // Live id classification; staleness outranks regression and gap checks.
  always_comb begin
    live_id    = feed.live_update_id;
    is_stale   = (live_id <= snap_id_q);
    is_regress = (live_id < last_id_q);
    id_delta   = live_id - last_id_q;
    is_gap     = !is_regress && (id_delta > MAX_GAP);
  end

  always_comb begin
    snap_rdy  = 1'b0;
    live_rdy  = 1'b0;
    state_d   = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        snap_rdy = 1'b1;
        if (feed.snap_valid && feed.snap_last) state_d = ST_LIVE;
      end
      ST_LIVE: begin
        live_rdy = 1'b1;
        if (feed.live_valid && !is_stale && (is_regress || is_gap)) state_d = ST_RESYNC;
      end
      ST_RESYNC: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      snap_rdy = 1'b0;
      live_rdy = 1'b0;
      state_d  = ST_IDLE;
    end
  end

  assign snap_fire = feed.snap_valid && snap_rdy;
  assign live_fire = feed.live_valid && live_rdy;
  assign live_fwd  = live_fire && !is_stale && !is_regress && !is_gap;
  assign live_bad  = live_fire && !is_stale && (is_regress || is_gap);

  always_comb begin
    beat_d      = beat_q;
    out_valid_d = 1'b0;
    if (snap_fire) begin
      out_valid_d = 1'b1;
      beat_d = '{ts_ns:     feed.snap_ts_ns,
                 update_id: feed.snap_update_id,
                 side:      feed.snap_side,
                 price_f32: feed.snap_price_f32,
                 qty_f32:   feed.snap_qty_f32,
                 is_snap:   1'b1};
    end else if (live_fwd) begin
      out_valid_d = 1'b1;
      beat_d = '{ts_ns:     feed.live_ts_ns,
                 update_id: feed.live_update_id,
                 side:      feed.live_side,
                 price_f32: feed.live_price_f32,
                 qty_f32:   feed.live_qty_f32,
                 is_snap:   1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      snap_id_q   <= '0;
      last_id_q   <= '0;
      drop_cnt_q  <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      if (snap_fire && feed.snap_last) begin
        snap_id_q <= feed.snap_update_id;
        last_id_q <= feed.snap_update_id;
      end else if (live_fwd) begin
        last_id_q <= live_id;
      end
      if (live_fire && is_stale && (drop_cnt_q != '1))
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      if (live_bad && (gap_cnt_q != '1))
        gap_cnt_q <= gap_cnt_q + CNT_W'(1);
    end
  end

  assign feed.snap_ready    = snap_rdy;
  assign feed.live_ready    = live_rdy;
  assign feed.out_valid     = out_valid_q;
  assign feed.out_ts_ns     = beat_q.ts_ns;
  assign feed.out_update_id = beat_q.update_id;
  assign feed.out_side      = beat_q.side;
  assign feed.out_price_f32 = beat_q.price_f32;
  assign feed.out_qty_f32   = beat_q.qty_f32;
  assign feed.out_is_snap   = beat_q.is_snap;

  assign state_o    = state_q;
  // RESYNC always lasts exactly one cycle, so the state decode is the entry pulse.
  assign resync_req = (state_q == ST_RESYNC);
  assign drop_cnt   = drop_cnt_q;
  assign gap_cnt    = gap_cnt_q;

endmodule

// File: tb/tb_depth_feed_sequencer.sv
// Directed bench for depth_feed_sequencer: snapshot replay, stale drops, gap/regression resync, abort, async reset.
// Inputs change 1ns after the rising edge and outputs are sampled there, away from the active edge.
module tb_depth_feed_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [1:0]  state_o;
  logic        resync_req;
  logic [31:0] drop_cnt;
  logic [31:0] gap_cnt;

  int total = 0;
  int bad   = 0;

  depth_feed_sequencer_if ifc ();

  depth_feed_sequencer #(.MAX_GAP(64'd1000), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .feed       (ifc),
    .state_o    (state_o),
    .resync_req (resync_req),
    .drop_cnt   (drop_cnt),
    .gap_cnt    (gap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_snap(input logic [63:0] id, input logic last, input logic [31:0] price);
    ifc.snap_valid     = 1'b1;
    ifc.snap_last      = last;
    ifc.snap_update_id = id;
    ifc.snap_ts_ns     = 64'd5000 + 64'(price);
    ifc.snap_side      = 8'd1;
    ifc.snap_price_f32 = price;
    ifc.snap_qty_f32   = 32'h3F80_0000;
  endtask

  task automatic live_beat(input logic [63:0] id);
    ifc.live_valid     = 1'b1;
    ifc.live_update_id = id;
    ifc.live_ts_ns     = id * 64'd10;
    ifc.live_side      = 8'd2;
    ifc.live_price_f32 = 32'h4000_0000 + id[31:0];
    ifc.live_qty_f32   = 32'h4100_0000;
    tick();
    ifc.live_valid     = 1'b0;
  endtask

  // Start a sync with a single-level snapshot carrying id; leaves the DUT in LIVE.
  task automatic run_snap(input logic [63:0] id);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_snap(id, 1'b1, 32'h4200_0000);
    tick();
    ifc.snap_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    ifc.snap_valid = 1'b0;
    ifc.snap_last = 1'b0;
    ifc.snap_update_id = '0;
    ifc.snap_ts_ns = '0;
    ifc.snap_side = '0;
    ifc.snap_price_f32 = '0;
    ifc.snap_qty_f32 = '0;
    ifc.live_valid = 1'b1;
    ifc.live_ts_ns = '0;
    ifc.live_update_id = 64'd7;
    ifc.live_side = '0;
    ifc.live_price_f32 = '0;
    ifc.live_qty_f32 = '0;

    #3;
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_out_id", ifc.out_update_id, 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_gap", 64'(gap_cnt), 64'd0);
    chk("rst_resync", 64'(resync_req), 64'd0);
    chk("rst_snap_ready", 64'(ifc.snap_ready), 64'd0);

    #9 rst = 1'b0;
    tick();
    chk("idle_live_ready", 64'(ifc.live_ready), 64'd0);
    chk("idle_no_start", 64'(state_o), 64'd0);
    ifc.live_valid = 1'b0;

    // Three-level snapshot, id 100, last on the third beat
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("snap_state", 64'(state_o), 64'd1);
    chk("snap_ready", 64'(ifc.snap_ready), 64'd1);
    chk("snap_live_ready", 64'(ifc.live_ready), 64'd0);
    set_snap(64'd100, 1'b0, 32'h4210_0000);
    tick();
    chk("snap1_valid", 64'(ifc.out_valid), 64'd1);
    chk("snap1_is_snap", 64'(ifc.out_is_snap), 64'd1);
    chk("snap1_id", ifc.out_update_id, 64'd100);
    chk("snap1_price", 64'(ifc.out_price_f32), 64'h4210_0000);
    set_snap(64'd100, 1'b0, 32'h4220_0000);
    tick();
    chk("snap2_valid", 64'(ifc.out_valid), 64'd1);
    chk("snap2_ts", ifc.out_ts_ns, 64'd5000 + 64'h4220_0000);
    chk("snap2_state", 64'(state_o), 64'd1);
    set_snap(64'd100, 1'b1, 32'h4230_0000);
    tick();
    ifc.snap_valid = 1'b0;
    chk("snap3_valid", 64'(ifc.out_valid), 64'd1);
    chk("snap3_price", 64'(ifc.out_price_f32), 64'h4230_0000);
    chk("snap3_state_live", 64'(state_o), 64'd2);
    chk("live_ready", 64'(ifc.live_ready), 64'd1);

    // Live 95,100 stale; 101,101,102 forwarded
    live_beat(64'd95);
    chk("live95_dropped", 64'(ifc.out_valid), 64'd0);
    live_beat(64'd100);
    chk("live100_dropped", 64'(ifc.out_valid), 64'd0);
    live_beat(64'd101);
    chk("live101_valid", 64'(ifc.out_valid), 64'd1);
    chk("live101_id", ifc.out_update_id, 64'd101);
    chk("live101_is_snap", 64'(ifc.out_is_snap), 64'd0);
    live_beat(64'd101);
    chk("live101b_valid", 64'(ifc.out_valid), 64'd1);
    live_beat(64'd102);
    chk("live102_valid", 64'(ifc.out_valid), 64'd1);
    chk("live102_ts", ifc.out_ts_ns, 64'd1020);
    chk("live102_side", 64'(ifc.out_side), 64'd2);
    tick();
    chk("live_idle_valid", 64'(ifc.out_valid), 64'd0);
    chk("live_hold_id", ifc.out_update_id, 64'd102);
    chk("drop_cnt_2", 64'(drop_cnt), 64'd2);
    chk("gap_cnt_0", 64'(gap_cnt), 64'd0);

    // Gap of 1898 from last_id 102
    live_beat(64'd2000);
    chk("gap_not_fwd", 64'(ifc.out_valid), 64'd0);
    chk("gap_cnt_1", 64'(gap_cnt), 64'd1);
    chk("gap_resync_req", 64'(resync_req), 64'd1);
    chk("gap_state", 64'(state_o), 64'd3);
    chk("resync_live_ready", 64'(ifc.live_ready), 64'd0);
    tick();
    chk("resync_pulse_end", 64'(resync_req), 64'd0);
    chk("resync_to_idle", 64'(state_o), 64'd0);

    // Delta of exactly MAX_GAP is accepted, then a regression resyncs
    run_snap(64'd100);
    chk("run2_live", 64'(state_o), 64'd2);
    live_beat(64'd150);
    chk("run2_150_fwd", 64'(ifc.out_valid), 64'd1);
    live_beat(64'd1150);
    chk("run2_gap_eq_max_fwd", 64'(ifc.out_valid), 64'd1);
    chk("run2_1150_id", ifc.out_update_id, 64'd1150);
    live_beat(64'd2151);
    chk("run2_gap_1001", 64'(state_o), 64'd3);
    chk("run2_gap_nofwd", 64'(ifc.out_valid), 64'd0);
    chk("run2_gap_cnt", 64'(gap_cnt), 64'd2);
    tick();

    run_snap(64'd100);
    live_beat(64'd150);
    chk("run3_150_fwd", 64'(ifc.out_valid), 64'd1);
    live_beat(64'd149);
    chk("regress_nofwd", 64'(ifc.out_valid), 64'd0);
    chk("regress_state", 64'(state_o), 64'd3);
    chk("regress_gap_cnt", 64'(gap_cnt), 64'd3);
    chk("regress_drop_same", 64'(drop_cnt), 64'd2);
    tick();
    chk("regress_idle", 64'(state_o), 64'd0);

    // start with abort: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 64'(state_o), 64'd0);

    // Abort mid-snapshot while a level is offered
    start = 1'b1;
    tick();
    start = 1'b0;
    set_snap(64'd300, 1'b0, 32'h4300_0000);
    tick();
    abort = 1'b1;
    #1;
    chk("abort_snap_ready", 64'(ifc.snap_ready), 64'd0);
    chk("abort_prior_beat", 64'(ifc.out_valid), 64'd1);
    chk("abort_prior_id", ifc.out_update_id, 64'd300);
    tick();
    abort = 1'b0;
    ifc.snap_valid = 1'b0;
    chk("abort_idle", 64'(state_o), 64'd0);
    chk("abort_no_accept", 64'(ifc.out_valid), 64'd0);
    chk("abort_keeps_gap", 64'(gap_cnt), 64'd3);

    // Async reset between edges while in LIVE
    run_snap(64'd100);
    live_beat(64'd101);
    chk("pre_rst_valid", 64'(ifc.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(ifc.out_valid), 64'd0);
    chk("arst_state", 64'(state_o), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    chk("arst_gap", 64'(gap_cnt), 64'd0);
    chk("arst_out_id", ifc.out_update_id, 64'd0);
    #1 rst = 1'b0;
    tick();
    run_snap(64'd500);
    chk("resync_run_valid", 64'(ifc.out_valid), 64'd1);
    chk("resync_run_id", ifc.out_update_id, 64'd500);
    chk("resync_run_live", 64'(state_o), 64'd2);
    live_beat(64'd500);
    chk("resync_run_drop", 64'(drop_cnt), 64'd1);
    live_beat(64'd501);
    chk("resync_run_fwd", ifc.out_update_id, 64'd501);
    chk("resync_run_fwd_valid", 64'(ifc.out_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
